// File: rtl/pkt_gen_pkg.sv
// pkt_gen_pkg: shared definitions for the synthetic traffic generator.
//   - pkt_gen_state_t : generator FSM states
//   - *_MSB/*_LSB     : metadata word field positions
//   - ADDR_*          : configuration register addresses
//   - LFSR_TAPS       : tap mask of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   - lfsr_step()     : one LFSR shift
package pkt_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } pkt_gen_state_t;

    localparam int SRC_MSB = 31;
    localparam int SRC_LSB = 30;
    localparam int DST_MSB = 29;
    localparam int DST_LSB = 28;
    localparam int LEN_MSB = 27;
    localparam int LEN_LSB = 22;
    localparam int TS_MSB  = 21;
    localparam int TS_LSB  = 11;
    localparam int SEQ_MSB = 10;
    localparam int SEQ_LSB = 0;

    localparam logic [1:0] ADDR_TOTAL    = 2'd0;
    localparam logic [1:0] ADDR_INTERVAL = 2'd1;
    localparam logic [1:0] ADDR_DEST     = 2'd2;
    localparam logic [1:0] ADDR_SEED     = 2'd3;

    // Bit i set = tap at stage i+1 (stages 16, 14, 13, 11).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pkt_gen_dest_pick.sv
// dest_pick: combinational "first enabled port strictly after N" picker.
//   mask  [3:0] : enabled egress ports (must be non-zero)
//   after [1:0] : search starts at after+1 and wraps; after itself is tried last
//   port  [1:0] : selected port
module dest_pick (
    input  logic [3:0] mask,
    input  logic [1:0] after,
    output logic [1:0] port
);
    logic [1:0] cand [4];
    logic [3:0] hit;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand[gi] = after + 2'(gi + 1);
        assign hit[gi]  = mask[cand[gi]];
    end

    // Descending scan so the closest enabled candidate is the one that sticks.
    always_comb begin
        port = after;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) port = cand[i];
        end
    end
endmodule

// File: rtl/pkt_gen.sv
// pkt_gen: per-port synthetic traffic generator feeding the ingress stage.
// Optional feature macro: PKT_GEN_LFSR_EN (LFSR-driven destination choice;
// when undefined the seed register is absent and selection is round-robin).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cfg_we/addr/wdata     : register writes (0 total, 1 interval, 2 mask/len, 3 seed)
//   start, stop           : experiment control pulses (stop wins)
//   ingress_in[_en]       : registered metadata word and its valid pulse
//   busy, done, sent_cnt  : status
module pkt_gen
    import pkt_gen_pkg::*;
#(
    parameter int SRC_PORT   = 0,
    parameter int META_WIDTH = 32,
    parameter int SEQ_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    input  logic                  start,
    input  logic                  stop,
    output logic [META_WIDTH-1:0] ingress_in,
    output logic                  ingress_in_en,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           sent_cnt
);
    pkt_gen_state_t        state_q, state_d;
    logic [15:0]           total_q, total_d;
    logic [15:0]           interval_q, interval_d;
    logic [3:0]            mask_q, mask_d;
    logic [5:0]            len_q, len_d;
    logic [15:0]           gap_q, gap_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [META_WIDTH-1:0] word_q, word_d;
    logic                  en_q, en_d;

    logic                  idle_like;
    logic                  launch;
    logic [3:0]            mask_eff;
    logic [1:0]            ptr_base;
    logic [1:0]            pick_after;
    logic [1:0]            pick;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    // A launch restarts the per-experiment counters in the same cycle the
    // first word is built, so the first word sees the cleared values.
    assign launch    = idle_like && start && !stop && (total_q != 16'd0);
    assign mask_eff  = (mask_q == 4'd0) ? 4'hF : mask_q;
    assign ptr_base  = launch ? 2'd3 : ptr_q;

`ifdef PKT_GEN_LFSR_EN
    logic [15:0] seed_q, seed_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] lfsr_base;

    assign lfsr_base  = launch ? ((seed_q == 16'd0) ? 16'h0001 : seed_q) : lfsr_q;
    // Candidate lfsr[1:0] itself is accepted, so search starts just before it.
    assign pick_after = lfsr_base[1:0] - 2'd1;

    always_comb begin
        seed_d = seed_q;
        lfsr_d = lfsr_q;
        if (cfg_we && idle_like && (cfg_addr == ADDR_SEED)) seed_d = cfg_wdata[15:0];
        if (en_d) lfsr_d = lfsr_step(lfsr_base);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seed_q <= '0;
            lfsr_q <= '0;
        end else begin
            seed_q <= seed_d;
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign pick_after = ptr_base;
`endif

    dest_pick u_dest_pick (
        .mask  (mask_eff),
        .after (pick_after),
        .port  (pick)
    );

    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        interval_d = interval_q;
        mask_d     = mask_q;
        len_d      = len_q;
        gap_d      = gap_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        ptr_d      = ptr_q;
        word_d     = word_q;
        en_d       = 1'b0;

        if (cfg_we && idle_like) begin
            case (cfg_addr)
                ADDR_TOTAL:    total_d    = cfg_wdata[15:0];
                ADDR_INTERVAL: interval_d = cfg_wdata[15:0];
                ADDR_DEST: begin
                    mask_d = cfg_wdata[3:0];
                    len_d  = cfg_wdata[13:8];
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (total_q != 16'd0) begin
                        state_d = ST_EMIT;
                        en_d    = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        cnt_d   = 16'd0;
                    end
                end
            end
            ST_EMIT: begin
                if (cnt_q == total_q) begin
                    state_d = ST_DONE;
                end else if (interval_q <= 16'd1) begin
                    en_d = 1'b1;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = interval_q - 16'd2;
                end
            end
            ST_GAP: begin
                if (gap_q == 16'd0) begin
                    state_d = ST_EMIT;
                    en_d    = 1'b1;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q;
            en_d    = 1'b0;
        end

        // The word is built on the edge entering EMIT so it is visible
        // during the EMIT cycle together with its valid pulse.
        if (en_d) begin
            word_d                          = '0;
            word_d[SRC_MSB:SRC_LSB]         = 2'(SRC_PORT);
            word_d[DST_MSB:DST_LSB]         = pick;
            word_d[LEN_MSB:LEN_LSB]         = len_q;
            word_d[SEQ_LSB +: SEQ_WIDTH]    = launch ? '0 : seq_q;
            seq_d                           = (launch ? '0 : seq_q) + SEQ_WIDTH'(1);
            cnt_d                           = (launch ? 16'd0 : cnt_q) + 16'd1;
            ptr_d                           = pick;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            total_q    <= '0;
            interval_q <= '0;
            mask_q     <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            cnt_q      <= '0;
            seq_q      <= '0;
            ptr_q      <= '0;
            word_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            interval_q <= interval_d;
            mask_q     <= mask_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            ptr_q      <= ptr_d;
            word_q     <= word_d;
            en_q       <= en_d;
        end
    end

    assign ingress_in    = word_q;
    assign ingress_in_en = en_q;
    assign busy          = (state_q == ST_EMIT) || (state_q == ST_GAP);
    assign done          = (state_q == ST_DONE);
    assign sent_cnt      = cnt_q;

endmodule

// File: tb/tb_pkt_gen.sv
// tb_pkt_gen: directed self-checking bench for pkt_gen (instance SRC_PORT = 2).
module tb_pkt_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        start;
    logic        stop;
    logic [31:0] ingress_in;
    logic        ingress_in_en;
    logic        busy;
    logic        done;
    logic [15:0] sent_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int s_cyc = 0;
    int done_at;
    logic [31:0] pw [$];
    int          pc [$];

    always #5 clk = ~clk;

    pkt_gen #(.SRC_PORT(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .start         (start),
        .stop          (stop),
        .ingress_in    (ingress_in),
        .ingress_in_en (ingress_in_en),
        .busy          (busy),
        .done          (done),
        .sent_cnt      (sent_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every emitted word with the cycle it was valid in.
    always @(posedge clk) begin
        #1;
        if (ingress_in_en === 1'b1) begin
            pw.push_back(ingress_in);
            pc.push_back(cyc);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [31:0] pwi(input int i);
        return (i < pw.size()) ? pw[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic int poff(input int i);
        return (i < pc.size()) ? pc[i] - s_cyc : -1;
    endfunction

    function automatic logic [15:0] gold_lfsr(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic cfg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic kick();
        @(negedge clk);
        pw.delete(); pc.delete();
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        done_at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_at = cyc - s_cyc;
                break;
            end
        end
        check_val("done_reached", done, 1'b1);
    endtask

    task automatic wait_offset(input int off);
        for (int i = 0; i < 1000 && (cyc - s_cyc) < off; i++) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] w;
        logic [15:0] l;
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; stop = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(1);
        check_val("rst_word", ingress_in, 32'h0);
        check_val("rst_en", ingress_in_en, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_cnt", sent_cnt, 16'd0);

        // Basic spacing / word format
        cfg(2'd0, 32'd3); cfg(2'd1, 32'd4); cfg(2'd2, 32'h050F);
        kick();
        wait_done(100);
        check_val("t1_npkt", pw.size(), 3);
        check_val("t1_off0", poff(0), 1);
        check_val("t1_off1", poff(1), 5);
        check_val("t1_off2", poff(2), 9);
        check_val("t1_w0", pwi(0), 32'h8140_0000);
        check_val("t1_w1", pwi(1), 32'h9140_0001);
        check_val("t1_w2", pwi(2), 32'hA140_0002);
        check_val("t1_done_at", done_at, 10);
        check_val("t1_cnt", sent_cnt, 16'd3);
        check_val("t1_busy", busy, 1'b0);

        // Back-to-back with sparse mask
        cfg(2'd1, 32'd0); cfg(2'd0, 32'd4); cfg(2'd2, 32'h000A);
        kick();
        wait_done(100);
        check_val("t2_npkt", pw.size(), 4);
        check_val("t2_w0", pwi(0), 32'h9000_0000);
        check_val("t2_w1", pwi(1), 32'hB000_0001);
        check_val("t2_w2", pwi(2), 32'h9000_0002);
        check_val("t2_w3", pwi(3), 32'hB000_0003);
        check_val("t2_off3", poff(3), 4);
        check_val("t2_done_at", done_at, 5);

        // Sequence wrap, mask 0 means all ports
        cfg(2'd0, 32'd2100); cfg(2'd1, 32'd1); cfg(2'd2, 32'h0000);
        kick();
        wait_done(2300);
        check_val("t3_npkt", pw.size(), 2100);
        check_val("t3_w4", pwi(4), 32'h8000_0004);
        check_val("t3_w2047", pwi(2047), 32'hB000_07FF);
        check_val("t3_w2048", pwi(2048), 32'h8000_0000);
        check_val("t3_w2099", pwi(2099), 32'hB000_0033);
        check_val("t3_last_off", poff(2099), 2100);
        check_val("t3_cnt", sent_cnt, 16'd2100);

        // Stop mid-experiment, then restart
        cfg(2'd0, 32'd10); cfg(2'd1, 32'd5); cfg(2'd2, 32'h000F);
        kick();
        wait_offset(8);
        stop = 1'b1;
        idle(1);
        stop = 1'b0;
        idle(20);
        check_val("t4_npkt", pw.size(), 2);
        check_val("t4_cnt", sent_cnt, 16'd2);
        check_val("t4_busy", busy, 1'b0);
        check_val("t4_done", done, 1'b0);
        kick();
        wait_done(100);
        check_val("t4r_npkt", pw.size(), 10);
        check_val("t4r_w0", pwi(0), 32'h8000_0000);
        check_val("t4r_off9", poff(9), 46);
        check_val("t4r_cnt", sent_cnt, 16'd10);

        // Interval write while busy is ignored
        cfg(2'd0, 32'd4); cfg(2'd1, 32'd3);
        kick();
        cfg(2'd1, 32'd7);
        wait_done(100);
        check_val("t5_off1", poff(1), 4);
        check_val("t5_off3", poff(3), 10);
        kick();
        wait_done(100);
        check_val("t5r_off1", poff(1), 4);

        // total == 0 goes straight to DONE
        cfg(2'd0, 32'd0);
        kick();
        idle(2);
        check_val("t6_done", done, 1'b1);
        check_val("t6_cnt", sent_cnt, 16'd0);
        check_val("t6_npkt", pw.size(), 0);

        // start and stop together: stop wins
        cfg(2'd0, 32'd3);
        @(negedge clk);
        pw.delete(); pc.delete();
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        idle(5);
        check_val("t7_npkt", pw.size(), 0);
        check_val("t7_done", done, 1'b0);
        check_val("t7_busy", busy, 1'b0);

        // Reset mid-experiment
        cfg(2'd0, 32'd5); cfg(2'd1, 32'd3);
        kick();
        wait_offset(5);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(10);
        check_val("t8_npkt", pw.size(), 2);
        check_val("t8_cnt", sent_cnt, 16'd0);
        check_val("t8_busy", busy, 1'b0);
        check_val("t8_word", ingress_in, 32'h0);

`ifdef PKT_GEN_LFSR_EN
        cfg(2'd0, 32'd8); cfg(2'd1, 32'd1); cfg(2'd3, 32'h0000_ACE1); cfg(2'd2, 32'h0001);
        kick();
        wait_done(100);
        for (int i = 0; i < 8; i++) begin
            w = pwi(i);
            check_val($sformatf("lf_m1_dst%0d", i), w[29:28], 2'd0);
        end
        cfg(2'd2, 32'h000F);
        for (int r = 0; r < 2; r++) begin
            kick();
            wait_done(100);
            l = 16'hACE1;
            for (int i = 0; i < 8; i++) begin
                w = pwi(i);
                check_val($sformatf("lf_r%0d_dst%0d", r, i), w[29:28], l[1:0]);
                l = gold_lfsr(l);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
